fp_mul_result_buffer: RTL and testbench
=======================================

// Module: fp_mul_result_buffer
// PURPOSE
//  Downstream stage of the combinational half-precision multiplier: captures each product and its
//  class flags via valid/ready, queues them in a first-word-fall-through FIFO, and keeps sticky
//  exception flags plus saturating NaN/Inf/Zero counters for status readout by the controller.
//  Decouples the multiplier's one-result-per-cycle output from a consumer that may stall.
// PARAMETERS
//  NEXP   5   exponent width of the IEEE-754 format (matches multiplier)
//  NSIG   10  stored significand width (matches multiplier)
//  DEPTH  4   FIFO entries; power of two, >= 2
//  CNTW   8   width of each class counter
// PORTS
//  clk          in   1            rising-edge clock
//  rst          in   1            asynchronous active-high reset
//  flush        in   1            sync: empty FIFO (pointers/occupancy only)
//  clr_stat     in   1            sync: clear sticky flags and all counters
//  in_valid     in   1            product valid from multiplier stage
//  in_ready     out  1            buffer can accept (= !full)
//  in_p         in   NEXP+NSIG+1  product word
//  in_flags     in   LAST_FLAG    class flags of product (one-hot)
//  out_valid    out  1            head entry valid (= !empty)
//  out_ready    in   1            consumer accepts head
//  out_p        out  NEXP+NSIG+1  head product (0 when empty)
//  out_flags    out  LAST_FLAG    head flags (0 when empty)
//  level        out  $clog2(DEPTH)+1  current occupancy
//  sticky_flags out  LAST_FLAG    OR of in_flags of all accepted entries since last clear
//  nan_cnt      out  CNTW         accepted entries with SNAN or QNAN set, saturating
//  inf_cnt      out  CNTW         accepted entries with INFINITY set, saturating
//  zero_cnt     out  CNTW         accepted entries with ZERO set, saturating
// BEHAVIOUR
//  - Reset (async, rst=1): pointers, level, sticky_flags, all counters = 0; in_ready=1,
//    out_valid=0, out_p=0, out_flags=0. FIFO storage need not be reset.
//  - push = in_valid & in_ready; pop = out_valid & out_ready. in_ready depends only on full,
//    never on out_ready (no pass-through when full; push+pop when full not possible).
//  - FWFT: entry pushed in cycle N is on out_p/out_flags with out_valid=1 in cycle N+1.
//  - push & pop same cycle (not empty, not full): level unchanged, both pointers advance.
//  - Pointers wrap modulo DEPTH; full/empty from level (level==DEPTH / level==0).
//  - in_valid while full: in_ready=0, upstream must hold data; nothing dropped, no stats update.
//  - flush: next cycle level=0, out_valid=0; overrides push and pop in the same cycle
//    (flushed-cycle input is NOT captured and NOT counted). Stats untouched by flush.
//  - Stats update only on push. sticky_flags |= in_flags; counters +1, saturate at 2^CNTW-1.
//  - clr_stat with push same cycle: stats take only the new entry's contribution
//    (sticky = in_flags, counters = 0/1). clr_stat alone: all stats 0 next cycle.
//  - in_flags all-zero (no class) accepted and queued normally; no counter moves.
//  - Reset asserted mid-stream: all queued entries lost, outputs go to reset values immediately.
// STRUCTURE
//  - Flag bit indices (SNAN, QNAN, INFINITY, ZERO, SUBNORMAL, NORMAL, LAST_FLAG) come from the
//    shared ieee-754-flags include; no local redefinition.
//  - One sub-module: fp_sync_fifo (WIDTH, DEPTH; push/pop/flush, FWFT, level) holding
//    {in_flags, in_p}; top level adds handshake mapping, sticky register and counters.
// TESTING (NEXP=5, NSIG=10, DEPTH=4, CNTW=8)
//  1 Push 0x3C00/NORMAL, 0x7C00/INFINITY, 0x0000/ZERO with out_ready=0 -> level=3, out_p=0x3C00,
//    inf_cnt=1, zero_cnt=1, sticky has NORMAL|INFINITY|ZERO; then pop 3 -> order preserved, level=0.
//  2 Push 5 with out_ready=0 -> in_ready=0 after 4th, 5th held; assert out_ready 1 cycle ->
//    5th accepted next cycle, level=4, nan/inf/zero counts include exactly 5 entries.
//  3 Continuous push+pop, 10 words, alternating 0x7E00/QNAN and 0x7D00/SNAN -> level stays 1,
//    out order matches, nan_cnt=10, pointers wrap twice without loss.
//  4 300 pushes of 0x8000/ZERO with out_ready=1 -> zero_cnt saturates at 255; clr_stat with
//    simultaneous push of 0xFC00/INFINITY -> inf_cnt=1, zero_cnt=0, sticky=INFINITY only.
//  5 Level=3, assert flush with in_valid=1 and out_ready=1 -> next cycle level=0, out_valid=0,
//    out_p=0, flushed-cycle input not counted; stats unchanged.
//  6 Level=2, assert rst mid-cycle (async) -> level, counters, sticky, out_valid go 0 before next
//    edge; after release first push appears at output next cycle.

Source files
------------

// File: rtl/fp_mul_result_buffer_pkg.sv
// Shared definitions for the half-precision multiplier result path.
// Flag bit positions are the single source for every consumer of the class-flag vector.
package fp_mul_result_buffer_pkg;

    localparam int SNAN      = 0;
    localparam int QNAN      = 1;
    localparam int INFINITY  = 2;
    localparam int ZERO      = 3;
    localparam int SUBNORMAL = 4;
    localparam int NORMAL    = 5;
    localparam int LAST_FLAG = 6;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } classHits_t;

    // Signalling and quiet NaNs share one counter.
    function automatic classHits_t classify(input logic [LAST_FLAG-1:0] flags);
        classHits_t hits;
        hits.nan  = flags[SNAN] | flags[QNAN];
        hits.inf  = flags[INFINITY];
        hits.zero = flags[ZERO];
        return hits;
    endfunction

endpackage

// File: rtl/fp_mul_result_buffer_sync_fifo.sv
// fp_sync_fifo: first-word-fall-through FIFO with occupancy output and synchronous flush.
// Head word is visible combinationally; reads as zero while empty.
module fp_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wrData,
    output logic [WIDTH-1:0]           rdData,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);

    // Flush wins over both ports; push is refused when full, pop when empty.
    assign doPush = push & ~full  & ~flush;
    assign doPop  = pop  & ~empty & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            if (doPush && !doPop)
                level <= level + (AW+1)'(1);
            else if (doPop && !doPush)
                level <= level - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= wrData;
    end

    assign rdData = empty ? '0 : mem[rdPtr];

endmodule

// File: rtl/fp_mul_result_buffer.sv
// Result buffer behind the half-precision multiplier: FWFT queue plus sticky flags and
// saturating NaN/Inf/Zero counters. in_ready tracks only FIFO fullness, never out_ready.
module fp_mul_result_buffer
    import fp_mul_result_buffer_pkg::*;
#(
    parameter int NEXP  = 5,
    parameter int NSIG  = 10,
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       clr_stat,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NEXP+NSIG:0]         in_p,
    input  logic [LAST_FLAG-1:0]       in_flags,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NEXP+NSIG:0]         out_p,
    output logic [LAST_FLAG-1:0]       out_flags,
    output logic [$clog2(DEPTH):0]     level,
    output logic [LAST_FLAG-1:0]       sticky_flags,
    output logic [CNTW-1:0]            nan_cnt,
    output logic [CNTW-1:0]            inf_cnt,
    output logic [CNTW-1:0]            zero_cnt
);

    localparam int PW = NEXP + NSIG + 1;
    localparam int EW = PW + LAST_FLAG;

    logic          fifoFull;
    logic          fifoEmpty;
    logic          pushReq;
    logic          popReq;
    logic          accept;
    logic [EW-1:0] headWord;
    classHits_t    hits;

    assign in_ready  = ~fifoFull;
    assign out_valid = ~fifoEmpty;
    assign pushReq   = in_valid & in_ready;
    assign popReq    = out_valid & out_ready;
    // A flushed cycle captures nothing, so it must not count either.
    assign accept    = pushReq & ~flush;
    assign hits      = classify(in_flags);

    fp_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) uFifo (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .push   (pushReq),
        .pop    (popReq),
        .wrData ({in_flags, in_p}),
        .rdData (headWord),
        .level  (level),
        .full   (fifoFull),
        .empty  (fifoEmpty)
    );

    assign {out_flags, out_p} = headWord;

    function automatic logic [CNTW-1:0] nextCount(input logic [CNTW-1:0] cur,
                                                  input logic            hit,
                                                  input logic            clr);
        logic [CNTW-1:0] base;
        base = clr ? '0 : cur;
        if (hit && (base != {CNTW{1'b1}}))
            return base + CNTW'(1);
        return base;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_flags <= '0;
            nan_cnt      <= '0;
            inf_cnt      <= '0;
            zero_cnt     <= '0;
        end else begin
            if (clr_stat)
                sticky_flags <= accept ? in_flags : '0;
            else if (accept)
                sticky_flags <= sticky_flags | in_flags;
            nan_cnt  <= nextCount(nan_cnt,  accept & hits.nan,  clr_stat);
            inf_cnt  <= nextCount(inf_cnt,  accept & hits.inf,  clr_stat);
            zero_cnt <= nextCount(zero_cnt, accept & hits.zero, clr_stat);
        end
    end

endmodule

// File: tb/tb_fp_mul_result_buffer.sv
// Randomised and directed bench for fp_mul_result_buffer against a queue-based model.
module tb_fp_mul_result_buffer;
    import fp_mul_result_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int CMAX  = 255;

    typedef logic [21:0] entry_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        flush = 0;
    logic        clr_stat = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [15:0] in_p = 0;
    logic [5:0]  in_flags = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [15:0] out_p;
    logic [5:0]  out_flags;
    logic [2:0]  level;
    logic [5:0]  sticky_flags;
    logic [7:0]  nan_cnt, inf_cnt, zero_cnt;

    int errors = 0;
    int checks = 0;

    entry_t q[$];
    logic [5:0] stickyM = 0;
    int nanM = 0, infM = 0, zeroM = 0;

    fp_mul_result_buffer #(.NEXP(5), .NSIG(10), .DEPTH(DEPTH), .CNTW(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .clr_stat(clr_stat),
        .in_valid(in_valid), .in_ready(in_ready), .in_p(in_p), .in_flags(in_flags),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_flags(out_flags),
        .level(level), .sticky_flags(sticky_flags),
        .nan_cnt(nan_cnt), .inf_cnt(inf_cnt), .zero_cnt(zero_cnt)
    );

    always #5 clk = ~clk;

    function automatic int bump(input int c, input bit hit);
        if (!hit) return c;
        return (c < CMAX) ? c + 1 : CMAX;
    endfunction

    function automatic logic [5:0] fbit(input int idx);
        logic [5:0] one;
        one = 6'd1;
        return one << idx;
    endfunction

    function automatic logic [5:0] randFlags();
        int r;
        r = $urandom_range(0, 6);
        return (r == 6) ? 6'd0 : fbit(r);
    endfunction

    // One clock with current inputs; model follows the behavioural rules.
    task automatic step();
        bit pushM, popM, isNan, isInf, isZero;
        entry_t e;
        pushM  = in_valid && (q.size() < DEPTH) && !flush;
        popM   = out_ready && (q.size() > 0) && !flush;
        e      = {in_flags, in_p};
        isNan  = pushM && (in_flags[SNAN] || in_flags[QNAN]);
        isInf  = pushM && in_flags[INFINITY];
        isZero = pushM && in_flags[ZERO];
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (popM) void'(q.pop_front());
            if (pushM) q.push_back(e);
        end
        if (clr_stat) begin
            stickyM = pushM ? in_flags : 6'd0;
            nanM = bump(0, isNan); infM = bump(0, isInf); zeroM = bump(0, isZero);
        end else begin
            if (pushM) stickyM = stickyM | in_flags;
            nanM = bump(nanM, isNan); infM = bump(infM, isInf); zeroM = bump(zeroM, isZero);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        flush = 0; clr_stat = 0; in_valid = 0; out_ready = 0;
    endtask

    task automatic clear_all();
        idle(); flush = 1; clr_stat = 1; step(); idle();
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_p !== 16'h0 || out_flags !== 6'h0) begin errors++; $display("FAIL reset_out_word: got %h/%h want 0/0", out_p, out_flags); end
        checks++; if (level !== 3'd0 || sticky_flags !== 6'd0) begin errors++; $display("FAIL reset_level_sticky: got %0d/%h want 0/0", level, sticky_flags); end
        checks++; if (nan_cnt !== 8'd0 || inf_cnt !== 8'd0 || zero_cnt !== 8'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", nan_cnt, inf_cnt, zero_cnt); end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_order();
        logic [15:0] words [3];
        logic [5:0]  flg [3];
        words[0] = 16'h3C00; flg[0] = fbit(NORMAL);
        words[1] = 16'h7C00; flg[1] = fbit(INFINITY);
        words[2] = 16'h0000; flg[2] = fbit(ZERO);
        clear_all();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_p = words[i]; in_flags = flg[i]; step();
        end
        idle();
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL order_level: got %0d want 3", level); end
        checks++; if (out_p !== 16'h3C00) begin errors++; $display("FAIL order_head: got %h want 3c00", out_p); end
        checks++; if (inf_cnt !== 8'd1 || zero_cnt !== 8'd1) begin errors++; $display("FAIL order_counts: got inf=%0d zero=%0d want 1/1", inf_cnt, zero_cnt); end
        checks++; if (sticky_flags !== (fbit(NORMAL) | fbit(INFINITY) | fbit(ZERO))) begin errors++; $display("FAIL order_sticky: got %h want %h", sticky_flags, fbit(NORMAL) | fbit(INFINITY) | fbit(ZERO)); end
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_p !== words[i] || out_flags !== flg[i] || out_valid !== 1'b1) begin errors++; $display("FAIL order_pop%0d: got %h/%h v=%b want %h/%h", i, out_p, out_flags, out_valid, words[i], flg[i]); end
            step();
        end
        idle();
        checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL order_drained: got level=%0d v=%b want 0/0", level, out_valid); end
    endtask

    task automatic test_full_hold();
        logic [5:0] flg [5];
        flg[0] = fbit(SNAN); flg[1] = fbit(QNAN); flg[2] = fbit(INFINITY);
        flg[3] = fbit(ZERO); flg[4] = fbit(INFINITY);
        clear_all();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_p = 16'(16'h1000 + i); in_flags = flg[i]; step();
        end
        checks++; if (in_ready !== 1'b0 || level !== 3'd4) begin errors++; $display("FAIL full_ready: got rdy=%b level=%0d want 0/4", in_ready, level); end
        in_p = 16'h1004; in_flags = flg[4];
        repeat (2) step();
        checks++; if (level !== 3'd4 || inf_cnt !== 8'd1) begin errors++; $display("FAIL full_held: got level=%0d inf=%0d want 4/1", level, inf_cnt); end
        out_ready = 1; step();
        out_ready = 0; step();
        in_valid = 0;
        checks++; if (level !== 3'd4 || out_p !== 16'h1001) begin errors++; $display("FAIL full_accept: got level=%0d head=%h want 4/1001", level, out_p); end
        checks++; if (nan_cnt !== 8'd2 || inf_cnt !== 8'd2 || zero_cnt !== 8'd1) begin errors++; $display("FAIL full_counts: got %0d/%0d/%0d want 2/2/1", nan_cnt, inf_cnt, zero_cnt); end
        checks++; if (q.size() != 4 || q[3][15:0] !== 16'h1004) begin errors++; $display("FAIL full_model_tail: got %0d entries want 4 ending 1004", q.size()); end
    endtask

    task automatic test_back_to_back();
        clear_all();
        in_valid = 1; in_p = 16'h7E00; in_flags = fbit(QNAN); step();
        out_ready = 1;
        for (int i = 1; i < 10; i++) begin
            checks++; if (out_p !== q[0][15:0] || out_flags !== q[0][21:16]) begin errors++; $display("FAIL b2b_head%0d: got %h/%h want %h/%h", i, out_p, out_flags, q[0][15:0], q[0][21:16]); end
            in_p = (i % 2) ? 16'h7D00 : 16'h7E00;
            in_flags = (i % 2) ? fbit(SNAN) : fbit(QNAN);
            step();
            checks++; if (level !== 3'd1) begin errors++; $display("FAIL b2b_level%0d: got %0d want 1", i, level); end
        end
        in_valid = 0;
        checks++; if (out_p !== 16'h7D00) begin errors++; $display("FAIL b2b_last: got %h want 7d00", out_p); end
        step(); idle();
        checks++; if (nan_cnt !== 8'd10 || level !== 3'd0) begin errors++; $display("FAIL b2b_nan: got nan=%0d level=%0d want 10/0", nan_cnt, level); end
    endtask

    task automatic test_saturation();
        clear_all();
        in_valid = 1; out_ready = 1; in_p = 16'h8000; in_flags = fbit(ZERO);
        repeat (300) step();
        checks++; if (zero_cnt !== 8'd255) begin errors++; $display("FAIL sat_zero: got %0d want 255", zero_cnt); end
        clr_stat = 1; in_p = 16'hFC00; in_flags = fbit(INFINITY); out_ready = 0;
        step(); idle();
        checks++; if (inf_cnt !== 8'd1 || zero_cnt !== 8'd0 || nan_cnt !== 8'd0) begin errors++; $display("FAIL clr_push_counts: got %0d/%0d/%0d want 0/1/0", nan_cnt, inf_cnt, zero_cnt); end
        checks++; if (sticky_flags !== fbit(INFINITY)) begin errors++; $display("FAIL clr_push_sticky: got %h want %h", sticky_flags, fbit(INFINITY)); end
        clr_stat = 1; step(); idle();
        checks++; if (sticky_flags !== 6'd0 || inf_cnt !== 8'd0) begin errors++; $display("FAIL clr_alone: got %h/%0d want 0/0", sticky_flags, inf_cnt); end
    endtask

    task automatic test_flush();
        logic [5:0] stk;
        logic [7:0] n, f, z;
        clear_all();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_p = 16'($urandom); in_flags = randFlags(); step();
        end
        stk = sticky_flags; n = nan_cnt; f = inf_cnt; z = zero_cnt;
        flush = 1; in_valid = 1; out_ready = 1; in_p = 16'h7C00; in_flags = fbit(INFINITY) | fbit(ZERO);
        step(); idle();
        checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_level: got %0d v=%b want 0/0", level, out_valid); end
        checks++; if (out_p !== 16'h0 || out_flags !== 6'h0) begin errors++; $display("FAIL flush_out: got %h/%h want 0/0", out_p, out_flags); end
        checks++; if (sticky_flags !== stk || nan_cnt !== n || inf_cnt !== f || zero_cnt !== z) begin errors++; $display("FAIL flush_stats: got %h %0d/%0d/%0d want %h %0d/%0d/%0d", sticky_flags, nan_cnt, inf_cnt, zero_cnt, stk, n, f, z); end
    endtask

    task automatic test_async_reset();
        clear_all();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; in_p = 16'h4000; in_flags = fbit(ZERO); step();
        end
        idle();
        #2 rst = 1;
        #1;
        checks++; if (level !== 3'd0 || out_valid !== 1'b0 || out_p !== 16'h0) begin errors++; $display("FAIL arst_fifo: got level=%0d v=%b p=%h want 0/0/0", level, out_valid, out_p); end
        checks++; if (zero_cnt !== 8'd0 || sticky_flags !== 6'd0) begin errors++; $display("FAIL arst_stats: got zero=%0d sticky=%h want 0/0", zero_cnt, sticky_flags); end
        @(negedge clk);
        rst = 0;
        q.delete(); stickyM = 0; nanM = 0; infM = 0; zeroM = 0;
        in_valid = 1; in_p = 16'h3555; in_flags = fbit(NORMAL); step(); idle();
        checks++; if (out_valid !== 1'b1 || out_p !== 16'h3555 || level !== 3'd1) begin errors++; $display("FAIL arst_first_push: got v=%b p=%h level=%0d want 1/3555/1", out_valid, out_p, level); end
    endtask

    task automatic test_random();
        clear_all();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            clr_stat  = ($urandom_range(0, 60) == 0);
            in_p      = 16'($urandom);
            in_flags  = randFlags();
            checks++; if (in_ready !== (q.size() < DEPTH) || out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_hs%0d: got rdy=%b v=%b want level %0d", c, in_ready, out_valid, q.size()); end
            step();
            checks++; if (level !== 3'(q.size())) begin errors++; $display("FAIL rnd_level%0d: got %0d want %0d", c, level, q.size()); end
            checks++; if ({out_flags, out_p} !== ((q.size() > 0) ? q[0] : 22'd0)) begin errors++; $display("FAIL rnd_head%0d: got %h want %h", c, {out_flags, out_p}, (q.size() > 0) ? q[0] : 22'd0); end
            checks++; if (sticky_flags !== stickyM || nan_cnt !== 8'(nanM) || inf_cnt !== 8'(infM) || zero_cnt !== 8'(zeroM)) begin errors++; $display("FAIL rnd_stats%0d: got %h %0d/%0d/%0d want %h %0d/%0d/%0d", c, sticky_flags, nan_cnt, inf_cnt, zero_cnt, stickyM, nanM, infM, zeroM); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_order();
        test_full_hold();
        test_back_to_back();
        test_saturation();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
